// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard scheduler: merges load-use, taken-branch, mul/div and data-memory
// wait conditions into prioritised per-stage write-enables and flushes, plus perf counters.
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_to_reg_id_ex,
  input  logic [4:0]       rt_id_ex,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic             use_rt_if_id,
  input  logic             branch_taken_ex,
  input  logic             muldiv_start_ex,
  input  logic             mem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int CW = $clog2(MULDIV_CYCLES);

  typedef enum logic {RUN, MULDIV} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             freeze, load_use, flush_evt;

  assign freeze   = mem_req_mem & ~dmem_ready;
  assign load_use = mem_to_reg_id_ex & (rt_id_ex != 5'd0) &
                    ((rt_id_ex == rs_if_id) | (use_rt_if_id & (rt_id_ex == rt_if_id)));

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_evt    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    muldiv_busy  = 1'b0;
    muldiv_done  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (!freeze) begin
          if (muldiv_start_ex) begin
            {pc_write, if_id_write, id_ex_write} = 3'b000;
            ex_mem_flush = 1'b1;
            muldiv_busy  = 1'b1;
            cnt_d        = CW'(MULDIV_CYCLES - 1);
            state_d      = MULDIV;
          end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
      MULDIV: begin
        muldiv_busy = 1'b1;
        if (cnt_q != '0) begin
          {pc_write, if_id_write, id_ex_write} = 3'b000;
          ex_mem_flush = 1'b1;
          cnt_d        = cnt_q - 1'b1;
        end else if (!freeze) begin
          muldiv_busy = 1'b0;
          muldiv_done = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // A data-memory wait overrides whatever the state logic chose for the stage controls.
    if (freeze) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush}           = 3'b000;
      mem_wb_flush = 1'b1;
      muldiv_done  = 1'b0;
    end

    if (rst) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write}      = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b0000;
      muldiv_busy = 1'b0;
      muldiv_done = 1'b0;
    end

    stall_d = (!pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d = (flush_evt && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all compared against
// a cycle-level model of the scheduling rules; a narrow-counter instance exercises saturation.
module tb_pipe_hazard_ctrl;

  localparam int MDC  = 32;
  localparam int SATW = 4;

  typedef struct packed {
    logic pc_w, ifid_w, idex_w, exmem_w;
    logic ifid_f, idex_f, exmem_f, memwb_f;
    logic busy, done;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_to_reg_id_ex, use_rt_if_id, branch_taken_ex, muldiv_start_ex, mem_req_mem, dmem_ready;
  logic [4:0] rt_id_ex, rs_if_id, rt_if_id;

  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_busy, muldiv_done;
  logic [15:0] stall_cycles, flush_events;

  logic s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_busy, s_done;
  logic [SATW-1:0] s_stall_cycles, s_flush_events;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mul/div in flight and how many stall cycles it still owes.
  bit md_active;
  int md_left;
  int stall_cnt, flush_cnt;
  ctl_t last;

  pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .mem_to_reg_id_ex(mem_to_reg_id_ex), .rt_id_ex(rt_id_ex), .rs_if_id(rs_if_id),
    .rt_if_id(rt_if_id), .use_rt_if_id(use_rt_if_id), .branch_taken_ex(branch_taken_ex),
    .muldiv_start_ex(muldiv_start_ex), .mem_req_mem(mem_req_mem), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .muldiv_busy(muldiv_busy),
    .muldiv_done(muldiv_done), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(SATW)) u_sat (
    .clk(clk), .rst(rst),
    .mem_to_reg_id_ex(mem_to_reg_id_ex), .rt_id_ex(rt_id_ex), .rs_if_id(rs_if_id),
    .rt_if_id(rt_if_id), .use_rt_if_id(use_rt_if_id), .branch_taken_ex(branch_taken_ex),
    .muldiv_start_ex(muldiv_start_ex), .mem_req_mem(mem_req_mem), .dmem_ready(dmem_ready),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
    .ex_mem_write(s_ex_mem_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush), .muldiv_busy(s_busy),
    .muldiv_done(s_done), .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t obs_vec();
    return '{pc_write, if_id_write, id_ex_write, ex_mem_write,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_busy, muldiv_done};
  endfunction

  function automatic logic [31:0] sat(input int v);
    return (v > (1 << SATW) - 1) ? (1 << SATW) - 1 : v;
  endfunction

  function automatic bit m_freeze();
    return mem_req_mem && !dmem_ready;
  endfunction

  function automatic bit m_load_use();
    return mem_to_reg_id_ex && rt_id_ex != 0 &&
           (rt_id_ex == rs_if_id || (use_rt_if_id && rt_id_ex == rt_if_id));
  endfunction

  // Expected stage controls for the current cycle from the scheduling rules.
  function automatic ctl_t model_ctl();
    ctl_t c;
    c = '{pc_w:1, ifid_w:1, idex_w:1, exmem_w:1, default:0};
    if (rst) return '0;
    if (md_active) begin
      if (md_left > 0 || m_freeze()) c.busy = 1;
      else c.done = 1;
      if (md_left > 0 && !m_freeze()) begin
        c.pc_w = 0; c.ifid_w = 0; c.idex_w = 0; c.exmem_f = 1;
      end
    end else if (!m_freeze()) begin
      if (muldiv_start_ex) begin
        c.pc_w = 0; c.ifid_w = 0; c.idex_w = 0; c.exmem_f = 1; c.busy = 1;
      end else if (branch_taken_ex) begin
        c.ifid_f = 1; c.idex_f = 1;
      end else if (m_load_use()) begin
        c.pc_w = 0; c.ifid_w = 0; c.idex_f = 1;
      end
    end
    if (m_freeze()) begin
      c.pc_w = 0; c.ifid_w = 0; c.idex_w = 0; c.exmem_w = 0;
      c.ifid_f = 0; c.idex_f = 0; c.exmem_f = 0; c.memwb_f = 1;
    end
    return c;
  endfunction

  task automatic model_reset();
    md_active = 0; md_left = 0; stall_cnt = 0; flush_cnt = 0;
  endtask

  task automatic model_update();
    ctl_t c;
    if (rst) begin
      model_reset();
      return;
    end
    c = model_ctl();
    if (!c.pc_w) stall_cnt++;
    if (!md_active && !m_freeze() && !muldiv_start_ex && branch_taken_ex) flush_cnt++;
    if (md_active) begin
      if (md_left > 0) md_left--;
      else if (!m_freeze()) md_active = 0;
    end else if (!m_freeze() && muldiv_start_ex) begin
      md_active = 1;
      md_left   = MDC - 1;  // the start cycle itself is the first stall
    end
  endtask

  // Called at posedge+1 with inputs already set; checks at negedge, advances model at posedge.
  task automatic step(input string tag);
    ctl_t e;
    @(negedge clk);
    e    = model_ctl();
    last = obs_vec();
    check({tag, "_ctl"}, 32'(last), 32'(e));
    check({tag, "_stall"}, 32'(stall_cycles), 32'(stall_cnt));
    check({tag, "_flush"}, 32'(flush_events), 32'(flush_cnt));
    check({tag, "_sat_stall"}, 32'(s_stall_cycles), sat(stall_cnt));
    check({tag, "_sat_flush"}, 32'(s_flush_events), sat(flush_cnt));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    mem_to_reg_id_ex = 0; rt_id_ex = 0; rs_if_id = 0; rt_if_id = 0; use_rt_if_id = 0;
    branch_taken_ex = 0; muldiv_start_ex = 0; mem_req_mem = 0; dmem_ready = 1;
  endtask

  initial begin
    int n_stall, done_at;
    rst = 1;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    check("reset_ctl", 32'(obs_vec()), 32'(0));
    check("reset_stall_cnt", 32'(stall_cycles), 32'(0));
    step("rst_hold");
    rst = 0;
    step("idle");
    check("idle_all_write", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write}), 32'hF);

    // Load-use on rs, then the zero-register and unused-rt exemptions.
    mem_to_reg_id_ex = 1; rt_id_ex = 8; rs_if_id = 8;
    step("lu_rs");
    check("lu_rs_bubble", 32'({last.pc_w, last.ifid_w, last.idex_f}), 32'b001);
    idle_inputs();
    step("lu_after");
    check("lu_stall_count", 32'(stall_cycles), 32'(1));
    mem_to_reg_id_ex = 1; rt_id_ex = 0; rs_if_id = 0;
    step("lu_r0");
    check("lu_r0_no_stall", 32'(last.pc_w), 32'(1));
    rt_id_ex = 8; rs_if_id = 3; rt_if_id = 8; use_rt_if_id = 0;
    step("lu_rt_unused");
    check("lu_rt_unused_no_stall", 32'(last.pc_w), 32'(1));
    use_rt_if_id = 1;
    step("lu_rt_used");
    idle_inputs();

    // Full mul/div latency with no memory wait.
    muldiv_start_ex = 1;
    n_stall = 0; done_at = -1;
    for (int i = 0; i < MDC + 3; i++) begin
      step("md");
      muldiv_start_ex = 0;
      if (!last.pc_w && last.exmem_f) n_stall++;
      if (last.done) begin
        if (done_at < 0) done_at = i;
        else done_at = 1000;
      end
    end
    check("md_stall_cycles", 32'(n_stall), 32'(MDC));
    check("md_done_cycle", 32'(done_at), 32'(MDC));
    check("sat_stall_pinned", 32'(s_stall_cycles), 32'((1 << SATW) - 1));

    // Taken branch wins over a simultaneous load-use.
    mem_to_reg_id_ex = 1; rt_id_ex = 5; rs_if_id = 5; branch_taken_ex = 1;
    step("br_lu");
    check("br_lu_flush", 32'({last.ifid_f, last.idex_f, last.pc_w}), 32'b111);
    idle_inputs();
    step("br_after");
    check("br_flush_count", 32'(flush_events), 32'(1));

    // Three-cycle memory wait hides a pending load-use until it ends.
    mem_to_reg_id_ex = 1; rt_id_ex = 9; rs_if_id = 9; mem_req_mem = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("frz");
      check("frz_controls", 32'({last.pc_w, last.exmem_w, last.memwb_f, last.idex_f}), 32'b0010);
    end
    dmem_ready = 1;
    step("frz_end");
    check("frz_end_lu", 32'({last.pc_w, last.idex_f}), 32'b01);
    idle_inputs();

    // Memory wait straddling the end of a mul/div defers done.
    muldiv_start_ex = 1;
    step("mdf_start");
    muldiv_start_ex = 0;
    for (int i = 0; i < MDC - 2; i++) step("mdf_run");
    mem_req_mem = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("mdf_frz");
      check("mdf_frz_busy", 32'({last.busy, last.done}), 32'b10);
    end
    dmem_ready = 1;
    step("mdf_done");
    check("mdf_done_pulse", 32'({last.busy, last.done}), 32'b01);
    idle_inputs();
    step("mdf_idle");

    // Asynchronous reset in the middle of a mul/div.
    muldiv_start_ex = 1;
    step("mdr_start");
    muldiv_start_ex = 0;
    for (int i = 0; i < 21; i++) step("mdr_run");
    #2 rst = 1;
    model_reset();
    #1;
    check("mdr_rst_ctl", 32'(obs_vec()), 32'(0));
    check("mdr_rst_cnt", 32'({stall_cycles, flush_events}), 32'(0));
    @(posedge clk); #1;
    step("mdr_hold");
    rst = 0;
    step("mdr_release");
    check("mdr_release_write", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, muldiv_busy}), 32'b11110);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      mem_to_reg_id_ex = 1'($urandom_range(0, 1));
      rt_id_ex         = 5'($urandom_range(0, 3));
      rs_if_id         = 5'($urandom_range(0, 3));
      rt_if_id         = 5'($urandom_range(0, 3));
      use_rt_if_id     = 1'($urandom_range(0, 1));
      branch_taken_ex  = ($urandom_range(0, 5) == 0);
      muldiv_start_ex  = ($urandom_range(0, 15) == 0);
      mem_req_mem      = 1'($urandom_range(0, 1));
      dmem_ready       = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It combines load-use detection, taken-branch flushing, multi-cycle mul/div sequencing and data-memory wait freezing into one prioritised set of per-stage write-enable and flush controls. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, and drives all of them. It also keeps saturating performance counters.

Parameters:
MULDIV_CYCLES, 32, cycles the mul/div unit occupies EX (must be >= 2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_to_reg_id_ex  in  1  instruction in ID/EX is a load
rt_id_ex  in  5  load destination register in ID/EX
rs_if_id  in  5  rs field of instruction in IF/ID
rt_if_id  in  5  rt field of instruction in IF/ID
use_rt_if_id  in  1  instruction in IF/ID reads rt as a source
branch_taken_ex  in  1  branch/jump resolved taken in EX
muldiv_start_ex  in  1  mul/div instruction in EX, first cycle
mem_req_mem  in  1  instruction in MEM accesses data memory
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
id_ex_write  out  1  ID/EX load enable
ex_mem_write  out  1  EX/MEM load enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  clear ID/EX to NOP
ex_mem_flush  out  1  clear EX/MEM to NOP
mem_wb_flush  out  1  clear MEM/WB to NOP
muldiv_busy  out  1  mul/div occupying EX
muldiv_done  out  1  one-cycle pulse: mul/div result valid in EX
stall_cycles  out  CNT_W  count of cycles with pc_write=0, saturating
flush_events  out  CNT_W  count of taken-branch flushes, saturating

Behaviour:
- FSM states: RUN, MULDIV. Down-counter cnt, width clog2(MULDIV_CYCLES).
- Reset (rst=1, immediate, asynchronous): state=RUN, cnt=0, both counters=0. While rst=1, all *_write=0, all *_flush=0, muldiv_busy=0, muldiv_done=0. This applies at any point, including mid-MULDIV.
- Outputs are combinational from state, cnt and inputs. Default is all writes=1 and all flushes=0.
- freeze = mem_req_mem & ~dmem_ready. It has the highest priority in every state:
  - pc/if_id/id_ex/ex_mem_write=0, mem_wb_flush=1, all other flushes=0, muldiv_done=0.
  - In RUN, the FSM takes no action. Branch and load-use are re-evaluated after freeze ends.
- load_use = mem_to_reg_id_ex & (rt_id_ex != 0) & ((rt_id_ex == rs_if_id) | (use_rt_if_id & (rt_id_ex == rt_if_id))).
- RUN, no freeze, priority order:
  1. muldiv_start_ex: pc/if_id/id_ex_write=0, ex_mem_flush=1, muldiv_busy=1, cnt<=MULDIV_CYCLES-1, next MULDIV.
  2. branch_taken_ex: if_id_flush=1, id_ex_flush=1, pc_write=1, flush_events++.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. One bubble per detection.
- MULDIV:
  - cnt>0: same stall outputs as the start cycle, muldiv_busy=1. cnt decrements, including during freeze.
  - cnt==0 and no freeze: muldiv_done=1, muldiv_busy=0, default outputs, next RUN.
  - cnt==0 and freeze: hold in MULDIV with muldiv_busy=1. Done is deferred until freeze is low.
  - branch_taken_ex and load_use are ignored in MULDIV.
- Latency: with no freeze, the start cycle plus MULDIV_CYCLES-1 further cycles are stalled. That is MULDIV_CYCLES stalled cycles, with done on the following cycle.
- Counters:
  - stall_cycles increments every non-reset cycle with pc_write=0.
  - flush_events increments per taken-branch flush cycle.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset mid-MULDIV (cnt=10): rst=1 -> immediately all writes=0, busy=0. After release: RUN, counters 0, all writes=1.
- Load-use: mem_to_reg_id_ex=1, rt_id_ex=8, rs_if_id=8 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1. Repeat with rt_id_ex=0 -> no stall. Repeat with rt match and use_rt_if_id=0 -> no stall.
- Mul/div, MULDIV_CYCLES=32: start at cycle 0 -> ex_mem_flush=1 and pc_write=0 for cycles 0..31, muldiv_done=1 at cycle 32 only, stall_cycles=32.
- Branch taken together with load_use -> if_id_flush=id_ex_flush=1, pc_write=1, no stall, flush_events=1.
- Freeze: dmem_ready=0 for 3 cycles with mem_req_mem=1 -> all writes=0 and mem_wb_flush=1 for 3 cycles. A concurrent load_use is acted on only in the 4th cycle.
- Freeze overlapping MULDIV end (cnt reaches 0 during freeze) -> busy held, done pulses in the first non-freeze cycle. Saturation: preload stall_cycles to all-ones -> stays at all-ones.
